// File: rtl/mopshub_uplink_arbiter_if.sv
// Signal bundle between the per-bus CAN receive paths and the shared MOPSHUB uplink.
// master is the arbiter side, slave is the bus/uplink environment side.
interface mopshub_uplink_arbiter_if #(
  parameter int N_BUSES = 8,
  parameter int DATA_W  = 76
);
  logic [N_BUSES-1:0]        bus_req;
  logic [N_BUSES*DATA_W-1:0] bus_frame;
  logic [N_BUSES-1:0]        bus_mask;
  logic [N_BUSES-1:0]        bus_ack;
  logic [DATA_W-1:0]         up_data;
  logic [4:0]                up_bus_id;
  logic                      up_valid;
  logic                      up_ready;
  logic                      busy;
  logic                      timeout_err;
  logic [15:0]               frame_cnt;
  logic [7:0]                drop_cnt;

  modport master (
    input  bus_req, bus_frame, bus_mask, up_ready,
    output bus_ack, up_data, up_bus_id, up_valid, busy, timeout_err, frame_cnt, drop_cnt
  );

  modport slave (
    output bus_req, bus_frame, bus_mask, up_ready,
    input  bus_ack, up_data, up_bus_id, up_valid, busy, timeout_err, frame_cnt, drop_cnt
  );
endinterface

// File: rtl/mopshub_uplink_arbiter.sv
// Round-robin arbiter sharing one MOPSHUB uplink between N CAN receive paths.
// A granted frame is held under valid/ready; a stalled uplink drops it after TIMEOUT_CYC.
module mopshub_uplink_arbiter #(
  parameter int N_BUSES     = 8,
  parameter int DATA_W      = 76,
  parameter int TIMEOUT_CYC = 1023
) (
  input logic                         clk,
  input logic                         rst,
  mopshub_uplink_arbiter_if.master    uif
);
  localparam int              IW       = $clog2(N_BUSES);
  localparam int              TW       = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0]   TO_VAL   = TW'(TIMEOUT_CYC);
  localparam bit              TO_EN    = (TIMEOUT_CYC != 0);
  localparam logic [IW-1:0]   LAST_RST = IW'(N_BUSES - 1);
  localparam logic [IW:0]     N_WIDE   = (IW+1)'(N_BUSES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SEND    = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [IW-1:0]       grant_idx_reg, grant_idx_next;
  logic [IW-1:0]       last_grant_reg, last_grant_next;
  logic [TW-1:0]       tmo_cnt_reg, tmo_cnt_next;
  logic [DATA_W-1:0]   up_data_reg, up_data_next;
  logic [4:0]          up_bus_id_reg, up_bus_id_next;
  logic                up_valid_reg, up_valid_next;
  logic [N_BUSES-1:0]  bus_ack_reg, bus_ack_next;
  logic                busy_reg;
  logic                timeout_err_reg, timeout_err_next;
  logic [15:0]         frame_cnt_reg, frame_cnt_next;
  logic [7:0]          drop_cnt_reg, drop_cnt_next;

  logic [N_BUSES-1:0]   eligible;
  logic [2*N_BUSES-1:0] elig_dbl;
  logic [N_BUSES-1:0]   elig_rot;
  logic [IW:0]          rr_off;
  logic [IW:0]          rr_sum;
  logic [IW-1:0]        rr_winner;
  logic [N_BUSES-1:0]   grant_onehot;
  logic [DATA_W-1:0]    frame_arr [2**IW];
  logic                 transfer;
  logic                 expire;

  assign eligible = uif.bus_req & uif.bus_mask;
  assign transfer = up_valid_reg & uif.up_ready;
  assign expire   = TO_EN && (tmo_cnt_reg == TO_VAL);

  // Unpack the flattened frame bus; padding entries keep the mux index power-of-two sized.
  generate
    for (genvar gi = 0; gi < 2**IW; gi++) begin : g_frame
      if (gi < N_BUSES) begin : g_live
        assign frame_arr[gi] = uif.bus_frame[gi*DATA_W +: DATA_W];
      end else begin : g_pad
        assign frame_arr[gi] = '0;
      end
    end
    for (genvar gi = 0; gi < N_BUSES; gi++) begin : g_onehot
      assign grant_onehot[gi] = (grant_idx_reg == IW'(gi));
    end
  endgenerate

  // Rotate the eligible set so bit 0 is last_grant+1, then take the lowest set bit.
  always_comb begin
    elig_dbl  = {eligible, eligible};
    elig_rot  = N_BUSES'(elig_dbl >> (last_grant_reg + 1'b1));
    rr_off    = '0;
    for (int i = N_BUSES - 1; i >= 0; i--) begin
      if (elig_rot[i]) rr_off = (IW+1)'(i);
    end
    rr_sum = {1'b0, last_grant_reg} + (IW+1)'(1) + rr_off;
    if (rr_sum >= N_WIDE) rr_sum = rr_sum - N_WIDE;
    rr_winner = rr_sum[IW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|eligible) state_next = CAPTURE;
      CAPTURE: state_next = SEND;
      SEND:    if (transfer || expire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    grant_idx_next   = grant_idx_reg;
    last_grant_next  = last_grant_reg;
    tmo_cnt_next     = tmo_cnt_reg;
    up_data_next     = up_data_reg;
    up_bus_id_next   = up_bus_id_reg;
    up_valid_next    = up_valid_reg;
    bus_ack_next     = '0;
    timeout_err_next = 1'b0;
    frame_cnt_next   = frame_cnt_reg;
    drop_cnt_next    = drop_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (|eligible) grant_idx_next = rr_winner;
      end
      CAPTURE: begin
        up_data_next    = frame_arr[grant_idx_reg];
        up_bus_id_next  = 5'(grant_idx_reg);
        up_valid_next   = 1'b1;
        bus_ack_next    = grant_onehot;
        last_grant_next = grant_idx_reg;
        tmo_cnt_next    = '0;
      end
      SEND: begin
        // A transfer in the expiry cycle takes priority over the drop.
        if (transfer) begin
          up_valid_next  = 1'b0;
          frame_cnt_next = frame_cnt_reg + 16'd1;
        end else if (expire) begin
          up_valid_next    = 1'b0;
          timeout_err_next = 1'b1;
          if (drop_cnt_reg != 8'hFF) drop_cnt_next = drop_cnt_reg + 8'd1;
        end else if (TO_EN) begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_idx_reg   <= '0;
      last_grant_reg  <= LAST_RST;
      tmo_cnt_reg     <= '0;
      up_data_reg     <= '0;
      up_bus_id_reg   <= '0;
      up_valid_reg    <= 1'b0;
      bus_ack_reg     <= '0;
      busy_reg        <= 1'b0;
      timeout_err_reg <= 1'b0;
      frame_cnt_reg   <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      grant_idx_reg   <= grant_idx_next;
      last_grant_reg  <= last_grant_next;
      tmo_cnt_reg     <= tmo_cnt_next;
      up_data_reg     <= up_data_next;
      up_bus_id_reg   <= up_bus_id_next;
      up_valid_reg    <= up_valid_next;
      bus_ack_reg     <= bus_ack_next;
      busy_reg        <= (state_next != IDLE);
      timeout_err_reg <= timeout_err_next;
      frame_cnt_reg   <= frame_cnt_next;
      drop_cnt_reg    <= drop_cnt_next;
    end
  end

  assign uif.bus_ack     = bus_ack_reg;
  assign uif.up_data     = up_data_reg;
  assign uif.up_bus_id   = up_bus_id_reg;
  assign uif.up_valid    = up_valid_reg;
  assign uif.busy        = busy_reg;
  assign uif.timeout_err = timeout_err_reg;
  assign uif.frame_cnt   = frame_cnt_reg;
  assign uif.drop_cnt    = drop_cnt_reg;
endmodule

// File: doc/mopshub_uplink_arbiter.md
# mopshub_uplink_arbiter

Round-robin scheduler that shares the single 76-bit MOPSHUB uplink between the per-bus CAN receive paths. Each bus presents a decoded frame (`{can_id, payload}`, 76 bits) with a request. The arbiter grants one bus at a time, latches its frame into an uplink holding register, and drives it out under a valid/ready handshake. A stalled uplink is bounded by a timeout that drops the frame and flags it.

## Interface
- `N_BUSES`, default 8: number of CAN bus receive paths, 2..32.
- `DATA_W`, default 76: frame width, `{can_id, data}`.
- `TIMEOUT_CYC`, default 1023: cycles `up_valid` may wait for `up_ready` before the frame is dropped. 0 disables the timeout.
- `clk`, input, 1: single clock for the whole block.
- `rst`, input, 1: asynchronous, active-high reset.
- `bus_req`, input, `N_BUSES`: per-bus frame request. Level signal, held until the matching `bus_ack`.
- `bus_frame`, input, `N_BUSES*DATA_W`: flattened frames. Bus i occupies bits `[i*DATA_W +: DATA_W]`. Must be stable while `bus_req[i]` is high.
- `bus_mask`, input, `N_BUSES`: 1 means the bus takes part in arbitration. Requests from a masked bus are ignored.
- `bus_ack`, output, `N_BUSES`: one-cycle one-hot pulse when bus i's frame is captured.
- `up_data`, output, `DATA_W`: uplink frame.
- `up_bus_id`, output, 5: index of the bus that sourced `up_data`.
- `up_valid`, output, 1: uplink frame valid.
- `up_ready`, input, 1: uplink consumer accepts the frame.
- `busy`, output, 1: state is not IDLE.
- `timeout_err`, output, 1: one-cycle pulse when a frame is dropped.
- `frame_cnt`, output, 16: frames accepted by the uplink. Wraps modulo 2^16.
- `drop_cnt`, output, 8: frames dropped on timeout. Saturates at 255.

## Operation
The FSM has three states: IDLE, CAPTURE and SEND.

**IDLE**
- Eligible set is `bus_req & bus_mask`.
- If the set is non-empty, the winner is the first eligible index searched from `last_grant+1` upward, wrapping modulo `N_BUSES`.
- Register the winner in `grant_idx` and go to CAPTURE.
- If the set is empty, stay in IDLE.

**CAPTURE** (always one cycle)
- `up_data <= bus_frame` slice of `grant_idx`, `up_bus_id <= grant_idx`, `up_valid <= 1`.
- `bus_ack[grant_idx]` pulses, `last_grant <= grant_idx`, timeout counter cleared.
- Go to SEND.

**SEND**
- If `up_valid && up_ready`: clear `up_valid`, `frame_cnt+1`, go to IDLE.
- Otherwise the timeout counter increments each cycle.
- When the counter equals `TIMEOUT_CYC` (nonzero) and `up_ready` is still low: clear `up_valid`, pulse `timeout_err`, `drop_cnt+1` (saturating), go to IDLE.
- If `up_ready` is high in that same cycle, the transfer wins and there is no drop.

**Other rules**
- `bus_mask` changes affect only future IDLE decisions. A frame in CAPTURE or SEND always completes or times out.
- `bus_req` from a bus deasserting before it is granted is simply not served. No ack is produced.
- Reset values:
  - State IDLE, `last_grant = N_BUSES-1` (bus 0 has first priority).
  - `up_data`, `up_bus_id`, `up_valid`, `bus_ack`, `busy`, `timeout_err`, `frame_cnt`, `drop_cnt` all 0.
- Reset mid-transfer discards the held frame without ack or count. The requester re-requests.

## Timing
- Request high before edge k (in IDLE): grant registered at edge k. At edge k+1, `up_valid=1`, `up_data` is valid and `bus_ack` is high for the cycle between edges k+1 and k+2.
- The requester must drop `bus_req` at the edge where it samples `bus_ack`. IDLE then never re-grants the same frame.
- The earliest transfer is at edge k+2, giving 3 cycles per frame at full throughput under continuous requests.
- `up_data` and `up_bus_id` are stable from edge k+1 until the transfer or drop. They hold their last value afterwards.
- Timeout: a drop occurs at the edge where the counter reaches `TIMEOUT_CYC`. That is `TIMEOUT_CYC+1` cycles after `up_valid` rose.
- `busy` is registered and equals (state != IDLE).
- All outputs are registered. There is no combinational path from `up_ready` or `bus_req` to any output.

## Test plan
- **Single request:** `N_BUSES=8`, `bus_req[3]=1`, mask all ones, `up_ready=1` → `bus_ack=8'h08` one cycle, `up_bus_id=3`, `up_data` equals the bus 3 frame, `up_valid` high for 1 cycle, `frame_cnt=1`.
- **Fairness:** all 8 buses request continuously with `up_ready=1` → grant order 0,1,…,7,0 and one frame every 3 cycles; after 16 frames `frame_cnt=16`.
- **Masking:** `bus_req=8'hFF`, `bus_mask=8'hA5` → only buses 0,2,5,7 are granted, in that order. Clearing the mask bit of bus 5 while it is in SEND still completes its frame.
- **Backpressure:** `up_ready` held low for 10 cycles, then high → `up_valid` and `up_data` are stable throughout, exactly one transfer, no `timeout_err`.
- **Timeout:** `TIMEOUT_CYC=4`, `up_ready=0` → `timeout_err` pulses 5 cycles after `up_valid` rose and `drop_cnt=1`. Repeating 300 times leaves `drop_cnt` at 255.
- **Reset mid-operation:** assert `rst` asynchronously while in SEND → all outputs immediately 0, state IDLE. After release, bus 0 is granted first when all buses request.
